// File: rtl/whack_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : whack_game_ctrl
// Purpose  : Round-level controller for the whack-a-mole game. Sequences
//            IDLE -> COUNTDOWN -> PLAY -> OVER, scores player button presses
//            against the scheduler's lit-mole mask, tracks round time and
//            difficulty level, and feeds the mole ON time back to the
//            scheduler.
// Ports    : clk, rst (async, active-high)
//            tick_1ms      - 1 ms strobe
//            start_btn     - debounced start level (rising edge = request)
//            hit_btn       - debounced mole buttons
//            active_mask   - one-hot/zero mask of the lit mole
//            game_active   - high only in PLAY
//            on_ms_cfg     - mole ON time for the scheduler
//            gap_ms_cfg    - constant gap time
//            score, level, time_left_s, game_state
//            hit_pulse, miss_pulse - one-cycle event strobes
// Options  : `define MISS_PENALTY_EN to make each miss cost one point.
// Revision : 1.0 - initial release
// ============================================================================
module whack_game_ctrl #(
    parameter int N_MOLES        = 18,
    parameter int ROUND_S        = 60,
    parameter int COUNTDOWN_S    = 3,
    parameter int HITS_PER_LEVEL = 5,
    parameter int MAX_LEVEL      = 7,
    parameter int BASE_ON_MS     = 900,
    parameter int ON_STEP_MS     = 100,
    parameter int MIN_ON_MS      = 300,
    parameter int GAP_MS         = 250
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_1ms,
    input  logic               start_btn,
    input  logic [N_MOLES-1:0] hit_btn,
    input  logic [N_MOLES-1:0] active_mask,
    output logic               game_active,
    output logic [15:0]        on_ms_cfg,
    output logic [15:0]        gap_ms_cfg,
    output logic [13:0]        score,
    output logic [2:0]         level,
    output logic [7:0]         time_left_s,
    output logic [1:0]         game_state,
    output logic               hit_pulse,
    output logic               miss_pulse
);

    localparam logic [13:0] SCORE_MAX = 14'd9999;
    localparam logic [9:0]  MS_LAST   = 10'd999;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_COUNTDOWN = 2'd1,
        S_PLAY      = 2'd2,
        S_OVER      = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [9:0]         ms_q, ms_d;
    logic [7:0]         time_q, time_d;
    logic [13:0]        score_q, score_d;
    logic [2:0]         level_q, level_d;
    logic [7:0]         hits_q, hits_d;
    logic               credit_q, credit_d;
    logic               hit_pulse_q, hit_pulse_d;
    logic               miss_pulse_q, miss_pulse_d;
    logic [15:0]        on_ms_q, on_ms_d;
    logic               start_prev_q;
    logic [N_MOLES-1:0] hit_prev_q;
    logic [N_MOLES-1:0] mask_q;

    logic               start_rise;
    logic [N_MOLES-1:0] hit_rise;
    logic               sec_tick;
    logic               hit_cand;
    logic               miss_cand;
    logic signed [16:0] on_raw;

    assign start_rise = start_btn & ~start_prev_q;
    assign hit_rise   = hit_btn & ~hit_prev_q;
    assign sec_tick   = tick_1ms && (ms_q == MS_LAST);
    assign hit_cand   = (state_q == S_PLAY) && !credit_q && (|(hit_rise & active_mask));
    assign miss_cand  = (state_q == S_PLAY) && (|(hit_rise & ~active_mask));

    // Computed wide and signed so a large level can never wrap past the floor.
    assign on_raw = 17'(BASE_ON_MS) - 17'(level_q) * 17'(ON_STEP_MS);

    always_comb begin
        state_d      = state_q;
        ms_d         = ms_q;
        time_d       = time_q;
        score_d      = score_q;
        level_d      = level_q;
        hits_d       = hits_q;
        credit_d     = credit_q;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;

        if (on_raw < $signed(17'(MIN_ON_MS))) begin
            on_ms_d = 16'(MIN_ON_MS);
        end else begin
            on_ms_d = on_raw[15:0];
        end

        if (tick_1ms) begin
            ms_d = (ms_q == MS_LAST) ? 10'd0 : ms_q + 10'd1;
        end

        // A new mole (or mole-off) re-arms credit; a credit below re-sets it.
        if (active_mask != mask_q) begin
            credit_d = 1'b0;
        end

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_rise) begin
                    state_d = S_COUNTDOWN;
                    ms_d    = 10'd0;
                    time_d  = 8'(COUNTDOWN_S);
                    score_d = 14'd0;
                    level_d = 3'd0;
                    hits_d  = 8'd0;
                end
            end
            S_COUNTDOWN: begin
                if (sec_tick) begin
                    if (time_q == 8'd1) begin
                        state_d = S_PLAY;
                        ms_d    = 10'd0;
                        time_d  = 8'(ROUND_S);
                    end else begin
                        time_d = time_q - 8'd1;
                    end
                end
            end
            S_PLAY: begin
                if (sec_tick) begin
                    if (time_q == 8'd1) begin
                        state_d = S_OVER;
                        ms_d    = 10'd0;
                        time_d  = 8'd0;
                    end else begin
                        time_d = time_q - 8'd1;
                    end
                end

                hit_pulse_d  = hit_cand;
                miss_pulse_d = miss_cand;

`ifdef MISS_PENALTY_EN
                if (hit_cand && miss_cand) begin
                    score_d = (score_q == 14'd0) ? 14'd1 : score_q;
                end else if (hit_cand) begin
                    score_d = (score_q < SCORE_MAX) ? score_q + 14'd1 : SCORE_MAX;
                end else if (miss_cand) begin
                    score_d = (score_q == 14'd0) ? 14'd0 : score_q - 14'd1;
                end
`else
                if (hit_cand) begin
                    score_d = (score_q < SCORE_MAX) ? score_q + 14'd1 : SCORE_MAX;
                end
`endif

                if (hit_cand) begin
                    credit_d = 1'b1;
                    // hits_in_level keeps wrapping even once level saturates.
                    if (hits_q + 8'd1 == 8'(HITS_PER_LEVEL)) begin
                        hits_d = 8'd0;
                        if (level_q < 3'(MAX_LEVEL)) begin
                            level_d = level_q + 3'd1;
                        end
                    end else begin
                        hits_d = hits_q + 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ms_q         <= 10'd0;
            time_q       <= 8'd0;
            score_q      <= 14'd0;
            level_q      <= 3'd0;
            hits_q       <= 8'd0;
            credit_q     <= 1'b0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            on_ms_q      <= 16'(BASE_ON_MS);
            start_prev_q <= 1'b0;
            hit_prev_q   <= '0;
            mask_q       <= '0;
        end else begin
            state_q      <= state_d;
            ms_q         <= ms_d;
            time_q       <= time_d;
            score_q      <= score_d;
            level_q      <= level_d;
            hits_q       <= hits_d;
            credit_q     <= credit_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            on_ms_q      <= on_ms_d;
            start_prev_q <= start_btn;
            hit_prev_q   <= hit_btn;
            mask_q       <= active_mask;
        end
    end

    assign game_active = (state_q == S_PLAY);
    assign game_state  = state_q;
    assign on_ms_cfg   = on_ms_q;
    assign gap_ms_cfg  = 16'(GAP_MS);
    assign score       = score_q;
    assign level       = level_q;
    assign time_left_s = time_q;
    assign hit_pulse   = hit_pulse_q;
    assign miss_pulse  = miss_pulse_q;

endmodule
`default_nettype wire
